// File: rtl/iot_event_sequencer_pkg.sv
// Shared definitions for the IoT event sequencer: default sizing and
// event direction encoding.
package iot_event_sequencer_pkg;

    localparam int N_DEV_DEFAULT = 8;
    localparam int ID_W_DEFAULT  = 3;

    localparam logic DIR_DOWN = 1'b0;
    localparam logic DIR_UP   = 1'b1;

endpackage

// File: rtl/iot_event_sequencer_if.sv
// Device-activity inputs and serialised event outputs of the sequencer.
interface iot_event_sequencer_if
    import iot_event_sequencer_pkg::*;
#(
    parameter int N_DEV = N_DEV_DEFAULT,
    parameter int ID_W  = ID_W_DEFAULT
);

    logic [N_DEV-1:0] dev_active;
    logic             en;
    logic             change;
    logic             on_off;
    logic [ID_W-1:0]  dev_id;
    logic [N_DEV-1:0] pending;

    modport master (
        output dev_active, en,
        input  change, on_off, dev_id, pending
    );

    modport slave (
        input  dev_active, en,
        output change, on_off, dev_id, pending
    );

endinterface

// File: rtl/iot_event_sequencer_rr_arbiter.sv
// Combinational round-robin arbiter: the first requester after ptr,
// wrapping modulo N_DEV, wins.
module rr_arbiter
    import iot_event_sequencer_pkg::*;
#(
    parameter int N_DEV = N_DEV_DEFAULT,
    parameter int ID_W  = ID_W_DEFAULT
) (
    input  logic [N_DEV-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    input  logic             en,
    output logic             gnt_valid,
    output logic [ID_W-1:0]  gnt_id,
    output logic [N_DEV-1:0] gnt
);

    always_comb begin
        int idx;
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        gnt_valid = 1'b0;
        gnt_id    = '0;
        gnt       = '0;
        idx       = 0;
        for (int k = 1; k <= N_DEV; k++) begin
            idx = (int'(ptr) + k) % N_DEV;
            if (en && !gnt_valid && req[idx]) begin
                gnt_valid = 1'b1;
                gnt_id    = ID_W'(idx);
                gnt[idx]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/iot_event_sequencer.sv
// Detects per-device connect/disconnect edges, keeps one pending event per
// device, and issues at most one event per clock in round-robin order.
module iot_event_sequencer
    import iot_event_sequencer_pkg::*;
#(
    parameter int N_DEV = N_DEV_DEFAULT,
    parameter int ID_W  = ID_W_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    iot_event_sequencer_if.slave  bus
);

    logic [N_DEV-1:0] dev_prev_q;
    logic [N_DEV-1:0] pending_q, pending_d;
    logic [N_DEV-1:0] pend_dir_q, pend_dir_d;
    logic [N_DEV-1:0] rise, fall, edges, gnt;
    logic [ID_W-1:0]  rr_ptr_q, dev_id_q, gnt_id;
    logic             change_q, on_off_q, gnt_valid;

    assign rise  = bus.dev_active & ~dev_prev_q;
    assign fall  = ~bus.dev_active & dev_prev_q;
    assign edges = rise | fall;

    rr_arbiter #(
        .N_DEV (N_DEV),
        .ID_W  (ID_W)
    ) u_arb (
        .req       (pending_q),
        .ptr       (rr_ptr_q),
        .en        (bus.en),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id),
        .gnt       (gnt)
    );

    always_comb begin
        pending_d  = pending_q;
        pend_dir_d = pend_dir_q;
        for (int i = 0; i < N_DEV; i++) begin
            if (edges[i] && (!pending_q[i] || gnt[i])) begin
                pending_d[i]  = 1'b1;
                pend_dir_d[i] = rise[i] ? DIR_UP : DIR_DOWN;
            end else if (edges[i]) begin
                // An edge on a still-pending device undoes it: net change is zero.
                pending_d[i] = 1'b0;
            end else if (gnt[i]) begin
                pending_d[i] = 1'b0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dev_prev_q <= '0;
            pending_q  <= '0;
            pend_dir_q <= '0;
            change_q   <= 1'b0;
            on_off_q   <= 1'b0;
            dev_id_q   <= '0;
            rr_ptr_q   <= ID_W'(N_DEV - 1);
        end else begin
            dev_prev_q <= bus.dev_active;
            pending_q  <= pending_d;
            pend_dir_q <= pend_dir_d;
            change_q   <= gnt_valid;
            if (gnt_valid) begin
                on_off_q <= pend_dir_q[gnt_id];
                dev_id_q <= gnt_id;
                rr_ptr_q <= gnt_id;
            end
        end
    end

    assign bus.change  = change_q;
    assign bus.on_off  = on_off_q;
    assign bus.dev_id  = dev_id_q;
    assign bus.pending = pending_q;

endmodule

// File: tb/tb_iot_event_sequencer.sv
// Directed bench for iot_event_sequencer with a running up/down scoreboard.
module tb_iot_event_sequencer;

    localparam int N_DEV = 8;
    localparam int ID_W  = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   ref_cnt = 0;

    iot_event_sequencer_if #(.N_DEV(N_DEV), .ID_W(ID_W)) bus ();

    iot_event_sequencer #(.N_DEV(N_DEV), .ID_W(ID_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle, sample after the edge, and track the issued net count.
    task automatic step();
        @(posedge clk);
        #1;
        if (bus.change === 1'b1) ref_cnt += (bus.on_off === 1'b1) ? 1 : -1;
        if (rst === 1'b1 && bus.pending === '0)
            check("scoreboard", ref_cnt, $countones(bus.dev_active));
    endtask

    task automatic pulse(input string tag, input logic dir, input logic [ID_W-1:0] id);
        check({tag, "_change"}, bus.change, 1'b1);
        check({tag, "_on_off"}, bus.on_off, dir);
        check({tag, "_dev_id"}, bus.dev_id, id);
    endtask

    initial begin
        bus.dev_active = 8'hFF;
        bus.en         = 1'b1;
        rst            = 1'b0;

        // Reset with every device already active
        #1;
        check("rst_change",  bus.change,  1'b0);
        check("rst_pending", bus.pending, 8'h00);
        check("rst_on_off",  bus.on_off,  1'b0);
        check("rst_dev_id",  bus.dev_id,  3'd0);
        repeat (3) begin
            step();
            check("rst_hold_change", bus.change, 1'b0);
        end
        rst = 1'b1;
        step();
        check("boot_pending", bus.pending, 8'hFF);
        check("boot_idle",    bus.change,  1'b0);
        for (int i = 0; i < 8; i++) begin
            step();
            pulse("boot", 1'b1, 3'(i));
        end
        check("boot_drained", bus.pending, 8'h00);
        step();
        check("boot_quiet", bus.change, 1'b0);

        // Upper four devices disconnect
        bus.dev_active = 8'h0F;
        step();
        check("dn4_pending", bus.pending, 8'hF0);
        for (int i = 4; i < 8; i++) begin
            step();
            pulse("dn4", 1'b0, 3'(i));
        end
        step();
        check("dn4_quiet", bus.change, 1'b0);

        // Single disconnect of device 2: pulse two edges after the change
        bus.dev_active = 8'h0B;
        step();
        check("dn2_first_edge", bus.change,  1'b0);
        check("dn2_pending",    bus.pending, 8'h04);
        step();
        pulse("dn2", 1'b0, 3'd2);
        check("dn2_cleared", bus.pending, 8'h00);
        step();
        check("dn2_single", bus.change, 1'b0);

        // Walk rr_ptr to 3 via devices 1 then 3
        bus.dev_active = 8'h09;
        step();
        step();
        pulse("dn1", 1'b0, 3'd1);
        bus.dev_active = 8'h01;
        step();
        step();
        pulse("dn3", 1'b0, 3'd3);
        step();

        // Fairness: 1, 3, 6 rise together with rr_ptr=3 -> 6, 1, 3
        bus.dev_active = 8'h4B;
        step();
        check("fair_pending", bus.pending, 8'h4A);
        check("fair_idle",    bus.change,  1'b0);
        step();
        pulse("fair_a", 1'b1, 3'd6);
        step();
        pulse("fair_b", 1'b1, 3'd1);
        step();
        pulse("fair_c", 1'b1, 3'd3);
        check("fair_drained", bus.pending, 8'h00);
        step();
        check("fair_quiet", bus.change, 1'b0);

        // Cancel: device 5 up then down while disabled
        bus.en         = 1'b0;
        bus.dev_active = 8'h6B;
        step();
        check("cancel_set", bus.pending, 8'h20);
        bus.dev_active = 8'h4B;
        step();
        check("cancel_clear", bus.pending, 8'h00);
        bus.en = 1'b1;
        step();
        check("cancel_no_pulse_a", bus.change, 1'b0);
        step();
        check("cancel_no_pulse_b", bus.change, 1'b0);

        // Stall: four events held while disabled, then released back-to-back
        bus.en         = 1'b0;
        bus.dev_active = 8'h77;
        step();
        check("stall_pending", bus.pending, 8'h3C);
        repeat (3) begin
            step();
            check("stall_hold_pending", bus.pending, 8'h3C);
            check("stall_hold_change",  bus.change,  1'b0);
        end
        bus.en = 1'b1;
        step();
        pulse("stall_a", 1'b1, 3'd4);
        step();
        pulse("stall_b", 1'b1, 3'd5);
        step();
        pulse("stall_c", 1'b1, 3'd2);
        step();
        pulse("stall_d", 1'b0, 3'd3);
        check("stall_drained", bus.pending, 8'h00);
        step();
        check("stall_quiet", bus.change, 1'b0);

        // Reset in the middle of a burst
        bus.dev_active = 8'h88;
        step();
        check("burst_pending", bus.pending, 8'hFF);
        step();
        pulse("burst_first", 1'b0, 3'd4);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_change",  bus.change,  1'b0);
        check("midrst_pending", bus.pending, 8'h00);
        ref_cnt = 0;
        step();
        check("midrst_hold", bus.change, 1'b0);
        rst = 1'b1;
        step();
        check("rerun_pending", bus.pending, 8'h88);
        step();
        pulse("rerun_a", 1'b1, 3'd3);
        step();
        pulse("rerun_b", 1'b1, 3'd7);
        check("rerun_drained", bus.pending, 8'h00);
        step();
        check("rerun_quiet", bus.change, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
